// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-channel round-robin arbiter.
package arb_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    // One-hot decode of a channel index.
    function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] idx);
        logic [NUM_CH-1:0] base;
        base = 4'b0001;
        return base << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter4_if;

    logic [3:0] req;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       gnt_valid;

    // Requester side.
    modport master (
        output req,
        input  gnt,
        input  s1,
        input  s0,
        input  gnt_valid
    );

    // Arbiter side.
    modport slave (
        input  req,
        output gnt,
        output s1,
        output s0,
        output gnt_valid
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit of mask,
// scanning ptr, ptr+1, ... modulo 4.
module rr_pick (
    input  logic [3:0] mask,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;

    // Scan the four channels starting at ptr; keep the first hit.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!any && mask[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-channel round-robin arbiter with bounded hold time, driving
// the one-hot grant and the binary select pair of a 4:1 data mux.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter4_if.slave  bus
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t        state;
    logic [1:0]    owner;
    logic [1:0]    ptr;
    logic [CW-1:0] hold_cnt;

    logic [3:0]    gnt_q;
    logic          s1_q;
    logic          s0_q;
    logic          valid_q;

    logic [1:0]    owner_inc;
    logic [3:0]    others;
    logic [3:0]    pick_mask;
    logic [1:0]    pick_ptr;
    logic [1:0]    pick_idx;
    logic          pick_any;

    // Feed the single picker: raw requests from IDLE; from GRANT the
    // competitors only, scanned from the channel after the owner so the
    // pick matches the pointer that is being written on the same edge.
    always_comb begin
        owner_inc = owner + 2'd1;
        others    = bus.req & ~onehot4(owner);
        pick_mask = bus.req;
        pick_ptr  = ptr;
        if (state == ST_GRANT) begin
            pick_mask = others;
            pick_ptr  = owner_inc;
        end
    end

    rr_pick u_pick (
        .mask (pick_mask),
        .ptr  (pick_ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Grant FSM with registered grant/select outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt_q    <= '0;
            s1_q     <= 1'b0;
            s0_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state    <= ST_GRANT;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                        gnt_q    <= onehot4(pick_idx);
                        s1_q     <= pick_idx[1];
                        s0_q     <= pick_idx[0];
                        valid_q  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!bus.req[owner]) begin
                        ptr <= owner_inc;
                        if (pick_any) begin
                            owner    <= pick_idx;
                            hold_cnt <= '0;
                            gnt_q    <= onehot4(pick_idx);
                            s1_q     <= pick_idx[1];
                            s0_q     <= pick_idx[0];
                        end else begin
                            state    <= ST_IDLE;
                            hold_cnt <= '0;
                            gnt_q    <= '0;
                            s1_q     <= 1'b0;
                            s0_q     <= 1'b0;
                            valid_q  <= 1'b0;
                        end
                    end else if (hold_cnt == HOLD_LAST && pick_any) begin
                        ptr      <= owner_inc;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                        gnt_q    <= onehot4(pick_idx);
                        s1_q     <= pick_idx[1];
                        s0_q     <= pick_idx[0];
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.s1        = s1_q;
    assign bus.s0        = s0_q;
    assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one instance with MAX_HOLD=8 and one
// with MAX_HOLD=4 (full-contention rotation), sharing clock and reset.
module tb_rr_arbiter4;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    rr_arbiter4_if bus8 ();
    rr_arbiter4_if bus4 ();

    rr_arbiter4 #(.MAX_HOLD(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    rr_arbiter4 #(.MAX_HOLD(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        bus8.req = 4'b0000;
        bus4.req = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    // Observed vector layout: {gnt[3:0], s1, s0, gnt_valid}.
    task automatic test_reset();
        logic [6:0] obs;
        rst      = 1'b1;
        bus8.req = 4'b1111;
        bus4.req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step();
            obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
            total_cnt++;
            if (obs !== 7'b0000_00_0)
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, 7'b0000_00_0);
            else pass_cnt++;
        end
        rst = 1'b0;
        step();
        obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
        total_cnt++;
        if (obs !== 7'b0001_00_1)
            $display("FAIL reset_first_grant: got %b expected %b", obs, 7'b0001_00_1);
        else pass_cnt++;
    endtask

    task automatic test_lone_holder();
        logic [6:0] obs;
        int         bad;
        apply_reset();
        bus8.req = 4'b0100;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
            total_cnt++;
            if (obs !== 7'b0100_10_1) begin
                $display("FAIL lone_holder[%0d]: got %b expected %b", i, obs, 7'b0100_10_1);
                bad++;
            end else pass_cnt++;
        end
        // Counter is saturated at 7: a newcomer preempts on the next edge.
        bus8.req = 4'b0101;
        step();
        obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
        total_cnt++;
        if (obs !== 7'b0001_00_1)
            $display("FAIL lone_then_preempt: got %b expected %b", obs, 7'b0001_00_1);
        else pass_cnt++;
    endtask

    task automatic test_full_contention();
        logic [6:0] obs;
        logic [6:0] exp;
        logic [3:0] exp_gnt [4];
        exp_gnt[0] = 4'b0001;
        exp_gnt[1] = 4'b0010;
        exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000;
        apply_reset();
        bus4.req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            step();
            exp = {exp_gnt[(i / 4) % 4], 2'((i / 4) % 4), 1'b1};
            obs = {bus4.gnt, bus4.s1, bus4.s0, bus4.gnt_valid};
            total_cnt++;
            if (obs !== exp)
                $display("FAIL contention[%0d]: got %b expected %b", i, obs, exp);
            else pass_cnt++;
        end
        bus4.req = 4'b0000;
    endtask

    task automatic test_handoff();
        logic [6:0] obs;
        apply_reset();
        bus8.req = 4'b0010;
        step();
        bus8.req = 4'b1010;
        step();
        obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
        total_cnt++;
        if (obs !== 7'b0010_01_1)
            $display("FAIL handoff_owner1: got %b expected %b", obs, 7'b0010_01_1);
        else pass_cnt++;
        bus8.req = 4'b1000;
        step();
        obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
        total_cnt++;
        if (obs !== 7'b1000_11_1)
            $display("FAIL handoff_no_bubble: got %b expected %b", obs, 7'b1000_11_1);
        else pass_cnt++;
    endtask

    // Continues from owner 3 left by test_handoff.
    task automatic test_ptr_wrap();
        logic [6:0] obs;
        bus8.req = 4'b0000;
        step();
        obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
        total_cnt++;
        if (obs !== 7'b0000_00_0)
            $display("FAIL wrap_idle: got %b expected %b", obs, 7'b0000_00_0);
        else pass_cnt++;
        bus8.req = 4'b1001;
        step();
        obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
        total_cnt++;
        if (obs !== 7'b0001_00_1)
            $display("FAIL wrap_ptr0: got %b expected %b", obs, 7'b0001_00_1);
        else pass_cnt++;
        bus8.req = 4'b1000;
        step();
        obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
        total_cnt++;
        if (obs !== 7'b1000_11_1)
            $display("FAIL wrap_release0: got %b expected %b", obs, 7'b1000_11_1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_grant();
        logic [6:0] obs;
        apply_reset();
        bus8.req = 4'b0100;
        step();
        step();
        obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
        total_cnt++;
        if (obs !== 7'b0100_10_1)
            $display("FAIL midrst_before: got %b expected %b", obs, 7'b0100_10_1);
        else pass_cnt++;
        rst = 1'b1;
        step();
        obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
        total_cnt++;
        if (obs !== 7'b0000_00_0)
            $display("FAIL midrst_cleared: got %b expected %b", obs, 7'b0000_00_0);
        else pass_cnt++;
        rst      = 1'b0;
        bus8.req = 4'b0110;
        step();
        obs = {bus8.gnt, bus8.s1, bus8.s0, bus8.gnt_valid};
        total_cnt++;
        if (obs !== 7'b0010_01_1)
            $display("FAIL midrst_ptr0: got %b expected %b", obs, 7'b0010_01_1);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        bus8.req  = 4'b0000;
        bus4.req  = 4'b0000;
        #2;
        test_reset();
        test_lone_holder();
        test_full_contention();
        test_handoff();
        test_ptr_wrap();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
